// File: rtl/me_pair_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : me_pair_scheduler_pkg
// Description : Shared constants and state encoding for the match-engine
//               pair scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package me_pair_scheduler_pkg;

    localparam int c_MEM_SIZE_DEF = 6;
    localparam int c_BX_BITS_DEF  = 3;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_FIN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/me_pair_scheduler_pair_counter.sv
`default_nettype none
// ============================================================================
// Module      : me_pair_scheduler_pair_counter
// Description : Stall-aware projection-outer / stub-inner index counter with
//               last-pair detect. Exposes the pair to be issued next.
// Revision    : 1.0 - initial release
// ============================================================================
module me_pair_scheduler_pair_counter
    import me_pair_scheduler_pkg::*;
#(
    parameter int MEM_SIZE = c_MEM_SIZE_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [MEM_SIZE-1:0] i_np,
    input  logic [MEM_SIZE-1:0] i_ns,
    input  logic                i_advance,
    output logic [MEM_SIZE-1:0] o_i,
    output logic [MEM_SIZE-1:0] o_j,
    output logic                o_last
);

    localparam logic [MEM_SIZE-1:0] c_ONE = {{(MEM_SIZE-1){1'b0}}, 1'b1};

    logic [MEM_SIZE-1:0] r_i;
    logic [MEM_SIZE-1:0] r_j;
    logic [MEM_SIZE-1:0] r_np;
    logic [MEM_SIZE-1:0] r_ns;
    logic [MEM_SIZE-1:0] w_i;
    logic [MEM_SIZE-1:0] w_j;
    logic [MEM_SIZE-1:0] w_np;
    logic [MEM_SIZE-1:0] w_ns;
    logic [MEM_SIZE-1:0] w_i_nxt;
    logic [MEM_SIZE-1:0] w_j_nxt;

    // A load makes (0,0) and the new counts visible in the same cycle so the
    // first pair can be issued on the start edge itself.
    always_comb begin
        w_i     = i_load ? '0 : r_i;
        w_j     = i_load ? '0 : r_j;
        w_np    = i_load ? i_np : r_np;
        w_ns    = i_load ? i_ns : r_ns;
        o_last  = (w_i == (w_np - c_ONE)) && (w_j == (w_ns - c_ONE));
        w_i_nxt = w_i;
        w_j_nxt = w_j;
        if (i_advance) begin
            if (w_j == (w_ns - c_ONE)) begin
                w_j_nxt = '0;
                w_i_nxt = w_i + c_ONE;
            end else begin
                w_j_nxt = w_j + c_ONE;
            end
        end
    end

    assign o_i = w_i;
    assign o_j = w_j;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i  <= '0;
            r_j  <= '0;
            r_np <= '0;
            r_ns <= '0;
        end else begin
            r_i  <= w_i_nxt;
            r_j  <= w_j_nxt;
            r_np <= w_np;
            r_ns <= w_ns;
        end
    end

endmodule
`default_nettype wire

// File: rtl/me_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : me_pair_scheduler
// Description : Per-BX sequencer issuing projection x stub read-address pairs
//               to the match engine VM memories, with stall, overrun and done.
// Revision    : 1.0 - initial release
// ============================================================================
module me_pair_scheduler
    import me_pair_scheduler_pkg::*;
#(
    parameter int MEM_SIZE = c_MEM_SIZE_DEF,
    parameter int BX_BITS  = c_BX_BITS_DEF
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MEM_SIZE-1:0]         number_proj,
    input  logic [MEM_SIZE-1:0]         number_stub,
    input  logic                        stall,
    output logic [BX_BITS+MEM_SIZE-1:0] read_add_proj,
    output logic [BX_BITS+MEM_SIZE-1:0] read_add_stub,
    output logic                        pair_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        truncated
);

    localparam logic [BX_BITS-1:0] c_BX_ONE = {{(BX_BITS-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_next_state;
    logic                        w_issue;
    logic                        w_zero;
    logic                        w_last;
    logic [MEM_SIZE-1:0]         w_cnt_i;
    logic [MEM_SIZE-1:0]         w_cnt_j;
    logic [BX_BITS-1:0]          r_bx;
    logic [BX_BITS-1:0]          w_bx_next;
    logic                        w_busy_next;
    logic                        w_done_next;
    logic                        w_trunc_next;
    logic [BX_BITS+MEM_SIZE-1:0] r_add_proj;
    logic [BX_BITS+MEM_SIZE-1:0] r_add_stub;
    logic                        r_pair_valid;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_truncated;

    me_pair_scheduler_pair_counter #(
        .MEM_SIZE (MEM_SIZE)
    ) u_pair_counter (
        .clk       (clk),
        .rst       (reset),
        .i_load    (start),
        .i_np      (number_proj),
        .i_ns      (number_stub),
        .i_advance (w_issue),
        .o_i       (w_cnt_i),
        .o_j       (w_cnt_j),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start overrides every state; the start edge itself issues pair (0,0).
    always_comb begin
        w_zero       = (number_proj == '0) || (number_stub == '0);
        w_next_state = r_state;
        w_issue      = 1'b0;
        if (start) begin
            w_issue      = !w_zero;
            w_next_state = (w_zero || w_last) ? c_FIN : c_RUN;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (!stall) begin
                        w_issue = 1'b1;
                        if (w_last) begin
                            w_next_state = c_FIN;
                        end
                    end
                end
                c_FIN:   w_next_state = c_IDLE;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // busy also covers the edge that issues the last pair, while the state
    // itself has already moved to FIN.
    always_comb begin
        w_busy_next  = (w_next_state == c_RUN) || w_issue;
        w_done_next  = (r_state == c_FIN);
        w_trunc_next = start && (r_state == c_RUN);
        w_bx_next    = start ? (r_bx + c_BX_ONE) : r_bx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bx         <= '1;
            r_add_proj   <= '0;
            r_add_stub   <= '0;
            r_pair_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_truncated  <= 1'b0;
        end else begin
            r_bx         <= w_bx_next;
            r_pair_valid <= w_issue;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_truncated  <= w_trunc_next;
            if (w_issue) begin
                r_add_proj <= {w_bx_next, w_cnt_i};
                r_add_stub <= {w_bx_next, w_cnt_j};
            end
        end
    end

    assign read_add_proj = r_add_proj;
    assign read_add_stub = r_add_stub;
    assign pair_valid    = r_pair_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign truncated     = r_truncated;

endmodule
`default_nettype wire

// File: doc/me_pair_scheduler.md
Name: me_pair_scheduler

Overview:
- Per-BX sequencer that drives a match engine's two VM memories.
- On each BX start pulse it captures the projection and stub counts for that BX. It then walks every projection×stub pair in projection-outer / stub-inner order, issuing one pair of registered read addresses per cycle.
- It honours downstream back-pressure, flags BX overruns, and signals completion.
- Sits between the BX timing fan-out and the match engine's memory read ports, replacing a free-running nested loop.

Parameters:
- MEM_SIZE, 6, address bits per BX within each VM memory; also the width of the count inputs.
- BX_BITS, 3, BX bits prefixed to both read addresses.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse marking a new BX
- number_proj  in  MEM_SIZE  projection count for the new BX; valid with start
- number_stub  in  MEM_SIZE  stub count for the new BX; valid with start
- stall  in  1  downstream cannot accept a pair this cycle
- read_add_proj  out  BX_BITS+MEM_SIZE  {bx, proj index}
- read_add_stub  out  BX_BITS+MEM_SIZE  {bx, stub index}
- pair_valid  out  1  read addresses valid this cycle
- busy  out  1  high in RUN state
- done  out  1  one-cycle pulse when a BX completes or is skipped
- truncated  out  1  one-cycle pulse when start pre-empts an unfinished BX

Behaviour:
- All outputs registered. Reset values:
  - addresses 0; pair_valid, busy, done, truncated 0
  - bx = all ones, so the first start yields bx 0
  - state IDLE
- States:
  - IDLE: wait for start.
  - RUN: iterate pairs.
  - FIN: one cycle; done=1, then IDLE.
- start in any state:
  - bx <= bx+1 (wraps modulo 2^BX_BITS); np, ns latched; i=j=0.
  - np==0 or ns==0 → FIN.
  - Otherwise → RUN.
- First pair: pair_valid=1 with i=0, j=0 in the cycle after start. Latency start→first pair = 1 clk.
- RUN, stall=0:
  - Present (i,j) with pair_valid=1.
  - Advance: j==ns-1 → j=0, i++; otherwise j++.
  - Once the pair (np-1, ns-1) has been presented, next state is FIN.
- RUN, stall=1: pair_valid=0; i, j and addresses held. No pair is lost or duplicated.
- Throughput: exactly np×ns valid cycles per BX absent stalls; 63×63=3969 maximum.
- start during RUN (BX overrun):
  - Current BX abandoned; truncated=1 for one cycle, coincident with the restart.
  - New BX begins immediately; done is not pulsed for the abandoned BX.
- start during FIN: done still pulses for the finished BX; the new BX starts as normal. done and the new pair_valid may coincide.
- reset mid-RUN: next cycle all outputs 0, bx all ones, IDLE.
- busy=1 exactly while in RUN.
- stall is ignored outside RUN.
- Counts are unsigned; no saturation needed at MEM_SIZE width.

Decomposition:
- Shared package/header: MEM_SIZE and BX_BITS defaults (same constants header as the other tracklet blocks); state encoding IDLE=2'd0, RUN=2'd1, FIN=2'd2.
- One natural sub-module, pair_counter: the stall-aware nested i/j counter with last-pair detect. The FSM, bx counter and output registers stay in the top level.

Test Plan:
- start, np=2, ns=3, no stall → 6 consecutive pair_valid cycles, proj/stub = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), bx=0; done one cycle after the last pair; busy high 6 cycles.
- start, np=0, ns=5 → no pair_valid; done 2 clk after start; bx increments to 1.
- np=2, ns=2, stall high on the cycles that would issue pairs 2 and 3 → pair_valid low on those cycles; sequence (0,0),(0,1),(1,0),(1,1) still complete, no duplicates; done after (1,1).
- np=4, ns=4, second start after 5 pairs:
  - truncated pulse coincides with the restart.
  - New BX restarts at (0,0) with bx incremented.
  - No done pulse for the first BX.
- 9 starts with np=ns=1 → bx field sequence 0..7,0, verifying wrap-around; one pair and one done per BX.
- reset asserted mid-RUN → next cycle pair_valid=0, busy=0; the following start issues bx=0.
